// File: rtl/breakout_game_ctrl_if.sv
// Signal bundle between the breakout frame logic and the game-flow sequencer.
// The pause member exists only when GAME_CTRL_PAUSE_EN is defined.
interface breakout_game_ctrl_if;
    logic       pixpulse;
    logic       frame_tick;
    logic       start;
    logic       ball_lost;
    logic       all_broken;
`ifdef GAME_CTRL_PAUSE_EN
    logic       pause;
`endif
    logic       move_en;
    logic       ball_respawn;
    logic       unbreak;
    logic [1:0] lives;
    logic [2:0] state;
    logic       game_over;
    logic       win;

`ifdef GAME_CTRL_PAUSE_EN
    modport master (output pixpulse, frame_tick, start, ball_lost, all_broken, pause,
                    input  move_en, ball_respawn, unbreak, lives, state, game_over, win);
    modport slave  (input  pixpulse, frame_tick, start, ball_lost, all_broken, pause,
                    output move_en, ball_respawn, unbreak, lives, state, game_over, win);
`else
    modport master (output pixpulse, frame_tick, start, ball_lost, all_broken,
                    input  move_en, ball_respawn, unbreak, lives, state, game_over, win);
    modport slave  (input  pixpulse, frame_tick, start, ball_lost, all_broken,
                    output move_en, ball_respawn, unbreak, lives, state, game_over, win);
`endif
endinterface

// File: rtl/breakout_game_ctrl.sv
// Game-flow sequencer: gates the per-frame move strobe, issues respawn/unbreak pulses, tracks lives.
// Latency: move_en combinational; state/lives/pulses registered; start/pause rise seen 3 clk after the raw edge.
// Backpressure: none, event driven; optional pause state enabled by GAME_CTRL_PAUSE_EN.
module breakout_game_ctrl #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int LOST_FRAMES  = 90,
    parameter int CNT_W        = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    breakout_game_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_LOST  = 3'd3,
        S_OVER  = 3'd4,
        S_WIN   = 3'd5,
        S_PAUSE = 3'd6
    } state_t;

    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] LOST_LAST  = CNT_W'(LOST_FRAMES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_lives;
    logic [1:0]       w_lives_nxt;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_respawn;
    logic             r_unbreak;
    logic             w_respawn_nxt;
    logic             w_unbreak_nxt;
    logic             w_tick;

    logic [1:0]       r_start_sync;
    logic             r_start_q;
    logic             r_start_rise;
    logic             w_pause_rise;

    // frame_tick is defined to coincide with pixpulse; qualifying with both keeps stray ticks out
    assign w_tick = bus.frame_tick & bus.pixpulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_sync <= 2'b00;
            r_start_q    <= 1'b0;
            r_start_rise <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[0], bus.start};
            r_start_q    <= r_start_sync[1];
            r_start_rise <= r_start_sync[1] & ~r_start_q;
        end
    end

`ifdef GAME_CTRL_PAUSE_EN
    logic [1:0] r_pause_sync;
    logic       r_pause_q;
    logic       r_pause_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pause_sync <= 2'b00;
            r_pause_q    <= 1'b0;
            r_pause_rise <= 1'b0;
        end else begin
            r_pause_sync <= {r_pause_sync[0], bus.pause};
            r_pause_q    <= r_pause_sync[1];
            r_pause_rise <= r_pause_sync[1] & ~r_pause_q;
        end
    end

    assign w_pause_rise = r_pause_rise;
`else
    assign w_pause_rise = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lives     <= LIVES_INIT;
            r_frame_cnt <= '0;
            r_respawn   <= 1'b0;
            r_unbreak   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lives   <= w_lives_nxt;
            r_respawn <= w_respawn_nxt;
            r_unbreak <= w_unbreak_nxt;
            if (w_state_nxt != r_state)
                r_frame_cnt <= '0;
            else if (w_tick && r_state != S_PAUSE)
                r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lives_nxt   = r_lives;
        w_respawn_nxt = 1'b0;
        w_unbreak_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_lives_nxt = LIVES_INIT;
                if (r_start_rise) begin
                    w_state_nxt   = S_SERVE;
                    w_respawn_nxt = 1'b1;
                    w_unbreak_nxt = 1'b1;
                end
            end
            S_SERVE: begin
                if (w_tick && r_frame_cnt == SERVE_LAST)
                    w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                // clearing the wall outranks losing the ball on the same frame
                if (w_tick && bus.all_broken) begin
                    w_state_nxt = S_WIN;
                end else if (w_tick && bus.ball_lost) begin
                    if (r_lives <= 2'd1) begin
                        w_lives_nxt = 2'd0;
                        w_state_nxt = S_OVER;
                    end else begin
                        w_lives_nxt = r_lives - 2'd1;
                        w_state_nxt = S_LOST;
                    end
                end else if (w_pause_rise) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_LOST: begin
                if (w_tick && r_frame_cnt == LOST_LAST) begin
                    w_state_nxt   = S_SERVE;
                    w_respawn_nxt = 1'b1;
                end
            end
            S_OVER, S_WIN: begin
                if (r_start_rise) begin
                    w_lives_nxt   = LIVES_INIT;
                    w_state_nxt   = S_SERVE;
                    w_respawn_nxt = 1'b1;
                    w_unbreak_nxt = 1'b1;
                end
            end
            S_PAUSE: begin
                if (w_pause_rise)
                    w_state_nxt = S_PLAY;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.move_en      = (r_state == S_PLAY) & w_tick;
        bus.ball_respawn = r_respawn;
        bus.unbreak      = r_unbreak;
        bus.lives        = r_lives;
        bus.state        = r_state;
        bus.game_over    = (r_state == S_OVER);
        bus.win          = (r_state == S_WIN);
    end
endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed bench for breakout_game_ctrl: serve, loss, game over, win, start glitch and mid-game reset.
module tb_breakout_game_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    breakout_game_ctrl_if gi();

    breakout_game_ctrl #(.LIVES(3), .SERVE_FRAMES(60), .LOST_FRAMES(90), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (gi.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_resp  = 0;
    int n_unb   = 0;

    always @(negedge clk) begin
        if (gi.ball_respawn === 1'b1) n_resp++;
        if (gi.unbreak === 1'b1) n_unb++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic bl, input logic ab, output logic me);
        @(posedge clk); #1;
        gi.frame_tick = 1'b1; gi.pixpulse = 1'b1; gi.ball_lost = bl; gi.all_broken = ab;
        @(negedge clk);
        me = gi.move_en;
        @(posedge clk); #1;
        gi.frame_tick = 1'b0; gi.pixpulse = 1'b0; gi.ball_lost = 1'b0; gi.all_broken = 1'b0;
    endtask

    task automatic run_ticks(input int n, output int me_cnt);
        logic me;
        me_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b0, me);
            if (me) me_cnt++;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (gi.state === s) ok = 1'b1;
        end
    endtask

    task automatic press_start(input int hold);
        @(posedge clk); #1 gi.start = 1'b1;
        repeat (hold) @(posedge clk);
        #1 gi.start = 1'b0;
    endtask

    task automatic test_reset;
        gi.start = 0; gi.ball_lost = 0; gi.all_broken = 0; gi.frame_tick = 0; gi.pixpulse = 0;
`ifdef GAME_CTRL_PAUSE_EN
        gi.pause = 0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 gi.frame_tick = 1'b1; gi.pixpulse = 1'b1;
        #1;
        n_tests++; if (gi.state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", gi.state); end
        n_tests++; if (gi.lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives got=%0d exp=3", gi.lives); end
        n_tests++; if (gi.move_en !== 1'b0) begin n_fail++; $display("FAIL reset_move_en got=%b exp=0", gi.move_en); end
        n_tests++; if ({gi.ball_respawn, gi.unbreak, gi.game_over, gi.win} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=0000", {gi.ball_respawn, gi.unbreak, gi.game_over, gi.win});
        end
        gi.frame_tick = 1'b0; gi.pixpulse = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_serve;
        int r0, u0, mc;
        bit ok;
        logic me;
        r0 = n_resp; u0 = n_unb;
        @(posedge clk); #1 gi.start = 1'b1;
        wait_state(3'd1, 20, ok);
        repeat (3) @(negedge clk);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL serve_enter got=%0d exp=1", gi.state); end
        n_tests++; if (n_resp - r0 != 1) begin n_fail++; $display("FAIL serve_respawn got=%0d exp=1", n_resp - r0); end
        n_tests++; if (n_unb - u0 != 1) begin n_fail++; $display("FAIL serve_unbreak got=%0d exp=1", n_unb - u0); end
        run_ticks(59, mc);
        n_tests++; if (gi.state !== 3'd1 || mc != 0) begin n_fail++; $display("FAIL serve_hold got=%0d/%0d exp=1/0", gi.state, mc); end
        tick(1'b0, 1'b0, me);
        n_tests++; if (gi.state !== 3'd2 || me !== 1'b0) begin n_fail++; $display("FAIL serve_tick60 got=%0d/%b exp=2/0", gi.state, me); end
        tick(1'b0, 1'b0, me);
        n_tests++; if (me !== 1'b1) begin n_fail++; $display("FAIL play_tick61 got=%b exp=1", me); end
        gi.start = 1'b0;
        press_start(1);
        repeat (8) @(negedge clk);
        n_tests++; if (gi.state !== 3'd2 || n_resp - r0 != 1 || n_unb - u0 != 1) begin
            n_fail++; $display("FAIL start_ignored got=%0d/%0d/%0d exp=2/1/1", gi.state, n_resp - r0, n_unb - u0);
        end
    endtask

    task automatic test_lost;
        int r0, mc;
        logic me;
        r0 = n_resp;
        tick(1'b1, 1'b0, me);
        n_tests++; if (me !== 1'b1) begin n_fail++; $display("FAIL lost_exit_move got=%b exp=1", me); end
        n_tests++; if (gi.state !== 3'd3 || gi.lives !== 2'd2) begin n_fail++; $display("FAIL lost_enter got=%0d/%0d exp=3/2", gi.state, gi.lives); end
        tick(1'b0, 1'b0, me);
        n_tests++; if (me !== 1'b0) begin n_fail++; $display("FAIL lost_move got=%b exp=0", me); end
        run_ticks(88, mc);
        @(negedge clk);
        n_tests++; if (gi.state !== 3'd3 || n_resp != r0 || mc != 0) begin n_fail++; $display("FAIL lost_hold got=%0d/%0d exp=3/0", gi.state, n_resp - r0); end
        tick(1'b0, 1'b0, me);
        repeat (3) @(negedge clk);
        n_tests++; if (gi.state !== 3'd1 || n_resp - r0 != 1) begin n_fail++; $display("FAIL lost_reserve got=%0d/%0d exp=1/1", gi.state, n_resp - r0); end
    endtask

    task automatic test_game_over;
        int u0, mc;
        bit ok;
        logic me;
        run_ticks(60, mc);
        tick(1'b1, 1'b0, me);
        n_tests++; if (gi.lives !== 2'd1 || gi.state !== 3'd3) begin n_fail++; $display("FAIL over_second_loss got=%0d/%0d exp=1/3", gi.lives, gi.state); end
        run_ticks(90, mc);
        run_ticks(60, mc);
        tick(1'b1, 1'b0, me);
        n_tests++; if (gi.state !== 3'd4 || gi.lives !== 2'd0 || gi.game_over !== 1'b1) begin
            n_fail++; $display("FAIL over_enter got=%0d/%0d/%b exp=4/0/1", gi.state, gi.lives, gi.game_over);
        end
        u0 = n_unb;
        press_start(1);
        wait_state(3'd1, 20, ok);
        repeat (3) @(negedge clk);
        n_tests++; if (!ok || gi.lives !== 2'd3 || n_unb - u0 != 1 || gi.game_over !== 1'b0) begin
            n_fail++; $display("FAIL over_restart got=%0d/%0d/%0d exp=1/3/1", gi.state, gi.lives, n_unb - u0);
        end
    endtask

    task automatic test_win;
        int mc;
        logic me;
        run_ticks(60, mc);
        tick(1'b1, 1'b1, me);
        n_tests++; if (gi.state !== 3'd5 || gi.win !== 1'b1 || gi.lives !== 2'd3 || me !== 1'b1) begin
            n_fail++; $display("FAIL win_priority got=%0d/%b/%0d/%b exp=5/1/3/1", gi.state, gi.win, gi.lives, me);
        end
    endtask

    task automatic test_start_glitch;
        int r0;
        bit ok;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        r0 = n_resp;
        press_start(2);
        wait_state(3'd1, 20, ok);
        repeat (10) @(negedge clk);
        n_tests++; if (!ok || gi.state !== 3'd1 || n_resp - r0 != 1) begin
            n_fail++; $display("FAIL glitch_one_transition got=%0d/%0d exp=1/1", gi.state, n_resp - r0);
        end
    endtask

    task automatic test_reset_mid;
        int r0, mc;
        logic me;
        run_ticks(60, mc);
        tick(1'b1, 1'b0, me);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        n_tests++; if (gi.state !== 3'd0 || gi.lives !== 2'd3) begin n_fail++; $display("FAIL midreset_async got=%0d/%0d exp=0/3", gi.state, gi.lives); end
        r0 = n_resp;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++; if (gi.state !== 3'd0 || n_resp != r0 || gi.unbreak !== 1'b0) begin
            n_fail++; $display("FAIL midreset_release got=%0d/%0d exp=0/0", gi.state, n_resp - r0);
        end
    endtask

`ifdef GAME_CTRL_PAUSE_EN
    task automatic test_pause;
        int mc;
        bit ok;
        press_start(1);
        wait_state(3'd1, 20, ok);
        run_ticks(60, mc);
        @(posedge clk); #1 gi.pause = 1'b1;
        @(posedge clk); #1 gi.pause = 1'b0;
        wait_state(3'd6, 20, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL pause_enter got=%0d exp=6", gi.state); end
        run_ticks(5, mc);
        n_tests++; if (mc != 0 || gi.state !== 3'd6 || gi.lives !== 2'd3) begin n_fail++; $display("FAIL pause_frozen got=%0d/%0d exp=0/6", mc, gi.state); end
        @(posedge clk); #1 gi.pause = 1'b1;
        @(posedge clk); #1 gi.pause = 1'b0;
        wait_state(3'd2, 20, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL pause_resume got=%0d exp=2", gi.state); end
    endtask
`endif

    initial begin
        test_reset;
        test_serve;
        test_lost;
        test_game_over;
        test_win;
        test_start_glitch;
        test_reset_mid;
`ifdef GAME_CTRL_PAUSE_EN
        test_pause;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/breakout_game_ctrl.md
# breakout_game_ctrl

Game-flow sequencer for the breakout VGA design. It sits between the VGA frame timing (the per-frame move pulse) and the ball, paddle and block instances. It gates the per-frame move strobe, issues ball-respawn and block-reset pulses, and tracks the remaining lives. It runs the IDLE, SERVE, PLAY, LOST, OVER and WIN states, so the playfield only animates during active play.

## Interface
Parameters:
- LIVES, 3, lives loaded at game start (1..3).
- SERVE_FRAMES, 60, frames frozen before play starts after a serve.
- LOST_FRAMES, 90, frames frozen after a ball is lost.
- CNT_W, 7, frame-counter width; must hold max(SERVE_FRAMES, LOST_FRAMES)-1.

Ports:
- clk  in  1  100 MHz system clock; the single clock.
- rst_n  in  1  asynchronous, active-low reset.
- pixpulse  in  1  25 MHz pixel-enable strobe, one clk wide.
- frame_tick  in  1  start-of-vblank pulse, one clk wide, coincident with pixpulse.
- start  in  1  raw pushbutton level (asynchronous).
- ball_lost  in  1  ball touched the bottom edge this frame; level, sampled on frame_tick.
- all_broken  in  1  every block is broken; level, sampled on frame_tick.
- pause  in  1  raw pushbutton level; present only with the macro defined.
- move_en  out  1  gated move strobe to the balls, paddle and blocks.
- ball_respawn  out  1  one-clk pulse that returns the balls to their start positions.
- unbreak  out  1  one-clk pulse that restores all blocks.
- lives  out  2  lives remaining.
- state  out  3  current state, encoded IDLE=0, SERVE=1, PLAY=2, LOST=3, OVER=4, WIN=5, PAUSE=6.
- game_over  out  1  high while in OVER.
- win  out  1  high while in WIN.

## Operation
- start is synchronized with a two-flop synchronizer; start_rise is the rising edge of the synchronized signal, evaluated every clk.
- frame_cnt is a CNT_W-bit counter. It increments only on frame_tick and clears on every state entry.
- IDLE:
  - lives is held at LIVES.
  - On start_rise: go to SERVE and pulse unbreak and ball_respawn in the same cycle.
- SERVE:
  - On a frame_tick with frame_cnt == SERVE_FRAMES-1: go to PLAY.
- PLAY:
  - move_en = frame_tick.
  - On frame_tick, all_broken has priority over ball_lost.
  - all_broken: go to WIN.
  - ball_lost with lives == 1: lives becomes 0; go to OVER.
  - ball_lost with lives > 1: lives decrements by 1; go to LOST.
- LOST:
  - On a frame_tick with frame_cnt == LOST_FRAMES-1: go to SERVE and pulse ball_respawn.
- OVER and WIN:
  - The matching flag (game_over or win) is high.
  - On start_rise: reload lives = LIVES, go to SERVE, and pulse unbreak and ball_respawn.
- move_en is 0 in every state except PLAY.
- lives saturates at 0 and never wraps.
- A start_rise in SERVE, PLAY or LOST is ignored.

## Timing
- Reset values: state = IDLE, lives = LIVES, frame_cnt = 0. All pulse outputs, move_en, game_over and win are 0.
- move_en is combinational from frame_tick and the registered state, so it has zero latency and lines up with the frame_tick cycle.
- State, lives, ball_respawn and unbreak are registered and update on the clk edge that samples the triggering event.
- Pulses are high for exactly one clk.
- start_rise reaches the FSM 3 clk after the raw start edge: two synchronizer flops plus one edge register.
- Frame-tick edges:
  - The frame_tick that causes a PLAY exit still produces move_en for that frame.
  - The frame_tick that causes SERVE→PLAY does not produce move_en.
- Reset asserted mid-operation returns immediately to the reset values; no pulse is emitted on release.

## Configuration
- Macro GAME_CTRL_PAUSE_EN.
- Defined:
  - The pause port exists, with its own two-flop synchronizer and rising-edge detector.
  - A pause rise in PLAY goes to PAUSE (state 6); frame_cnt and lives are frozen and move_en = 0.
  - A pause rise in PAUSE returns to PLAY.
  - In PAUSE, start_rise is ignored.
- Undefined:
  - No pause port; state 6 is unreachable.

## Test plan
- Reset, then start rise → ball_respawn and unbreak pulse once; state = 1. After 60 frame_ticks, state = 2; move_en first seen on frame_tick 61.
- In PLAY with lives = 3, assert ball_lost on one frame_tick → lives = 2, state = 3, move_en = 0. After 90 ticks, state = 1 with one ball_respawn pulse.
- Lose three balls from lives = 3 → lives = 0, state = 4, game_over = 1. Start rise → lives = 3, state = 1, unbreak pulse.
- all_broken and ball_lost on the same frame_tick → state = 5, win = 1, lives unchanged.
- Start held high through SERVE and PLAY → no extra pulses; a 2-clk start glitch in IDLE → exactly one transition.
- Drop rst_n during LOST → state = 0 and lives = 3 immediately; with GAME_CTRL_PAUSE_EN, pause rise in PLAY → state = 6 and move_en stays 0 across 5 frame_ticks.
